// File: rtl/pipe_pkg.sv
// Shared state encoding and saturating-add helper for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Adds inc to cnt and clamps at 2^width-1; width must be 1..32.
    function automatic logic [31:0] sat_add(
        input logic [31:0] cnt,
        input logic [31:0] inc,
        input int unsigned width
    );
        logic [32:0] sum_v;
        logic [32:0] max_v;
        max_v = (33'd1 << width) - 33'd1;
        sum_v = {1'b0, cnt} + {1'b0, inc};
        if (sum_v > max_v) begin
            return max_v[31:0];
        end else begin
            return sum_v[31:0];
        end
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage: W-wide register with load enable and synchronous active-low clear.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] slot_q;

    // Clear wins over load so an invalid slot always reads as zero.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            slot_q <= '0;
        end else if (ld_i) begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid slot, flush-to-bubble and
// saturating stall/kill statistics counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam int W = CTRL_W + DATA_W;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] kill_cnt_q;
    logic [W-1:0]     main_q;
    logic [W-1:0]     skid_q;
    logic [W-1:0]     main_d;
    logic [W-1:0]     in_vec_s;
    logic             main_ld_s;
    logic             main_clr_s;
    logic             skid_ld_s;
    logic             skid_clr_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             out_valid_s;
    logic [1:0]       held_s;
    logic [1:0]       kill_inc_s;

    assign in_vec_s    = {in_ctrl, in_data};
    assign out_valid_s = (state_q != ST_EMPTY);
    assign in_ready    = flush | ((SKID != 0) ? (state_q != ST_TWO) : (~out_valid_s | out_ready));
    assign in_fire_s   = in_valid & in_ready;
    assign out_fire_s  = out_valid_s & out_ready;

    // Held entries that a flush this cycle would discard without delivering.
    always_comb begin
        held_s = 2'd0;
        case (state_q)
            ST_ONE:  held_s = 2'd1;
            ST_TWO:  held_s = 2'd2;
            default: held_s = 2'd0;
        endcase
        kill_inc_s = held_s - {1'b0, out_fire_s};
    end

    // Next state and slot load/clear controls.
    always_comb begin
        state_d    = state_q;
        main_d     = in_vec_s;
        main_ld_s  = 1'b0;
        main_clr_s = 1'b0;
        skid_ld_s  = 1'b0;
        skid_clr_s = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d   = ST_ONE;
                        main_ld_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_ld_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_d   = ST_TWO;
                        skid_ld_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_d    = ST_EMPTY;
                        main_clr_s = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_d    = ST_ONE;
                        main_d     = skid_q;
                        main_ld_s  = 1'b1;
                        skid_clr_s = 1'b1;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state and saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (out_valid_s && !out_ready) begin
                stall_cnt_q <= CNT_W'(sat_add(32'(stall_cnt_q), 32'd1, CNT_W));
            end
            if (flush) begin
                kill_cnt_q <= CNT_W'(sat_add(32'(kill_cnt_q), {30'd0, kill_inc_s}, CNT_W));
            end
        end
    end

    pipe_slot #(.W(W)) u_main (
        .clk     (clk),
        .clr_n_i (rst & ~main_clr_s),
        .ld_i    (main_ld_s),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(W)) u_skid (
            .clk     (clk),
            .clr_n_i (rst & ~skid_clr_s),
            .ld_i    (skid_ld_s),
            .d_i     (in_vec_s),
            .q_o     (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = '0;
    end

    assign out_valid = out_valid_s;
    assign out_ctrl  = main_q[W-1:DATA_W];
    assign out_data  = main_q[DATA_W-1:0];
    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three stage instances (SKID=1/CNT_W=16, SKID=0/CNT_W=16, SKID=1/CNT_W=4) from shared stimulus
// and compares each against a small FIFO-occupancy model every cycle.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [15:0]  in_ctrl = 16'd0;
    logic [159:0] in_data = 160'd0;

    logic [2:0]         rdy_w;
    logic [2:0]         ov_w;
    logic [2:0][15:0]   oc_w;
    logic [2:0][159:0]  od_w;
    logic [2:0][15:0]   sc_w;
    logic [2:0][15:0]   kc_w;

    int      total = 0;
    int      bad = 0;
    bit      chk_en = 1'b0;
    int      mcnt[3];
    logic [175:0] mslot[3][2];
    longint  mstall[3];
    longint  mkill[3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_w[0]), .out_ready(out_ready),
        .out_ctrl(oc_w[0]), .out_data(od_w[0]), .stall_cnt(sc_w[0]), .kill_cnt(kc_w[0])
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_w[1]), .out_ready(out_ready),
        .out_ctrl(oc_w[1]), .out_data(od_w[1]), .stall_cnt(sc_w[1]), .kill_cnt(kc_w[1])
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_w[2]), .out_ready(out_ready),
        .out_ctrl(oc_w[2]), .out_data(od_w[2]), .stall_cnt(sc_w[2][3:0]), .kill_cnt(kc_w[2][3:0])
    );

    assign sc_w[2][15:4] = 12'd0;
    assign kc_w[2][15:4] = 12'd0;

    function automatic bit is_skid(int i);
        return (i != 1);
    endfunction

    function automatic longint sat(longint v, int i);
        longint mx;
        mx = (i == 2) ? 64'd15 : 64'd65535;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [175:0] mk(int x);
        return {16'(x), 160'(x)};
    endfunction

    function automatic bit exp_rdy(int i);
        if (flush) return 1'b1;
        if (is_skid(i)) return (mcnt[i] < 2);
        return (mcnt[i] == 0) || (out_ready == 1'b1);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, inst, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [175:0] head;
        for (int i = 0; i < 3; i++) begin
            head = (mcnt[i] > 0) ? mslot[i][0] : 176'd0;
            chk("out_valid", i, 192'(ov_w[i]), 192'(mcnt[i] > 0));
            chk("out_ctrl", i, 192'(oc_w[i]), 192'(head[175:160]));
            chk("out_data", i, 192'(od_w[i]), 192'(head[159:0]));
            chk("in_ready", i, 192'(rdy_w[i]), 192'(exp_rdy(i)));
            chk("stall_cnt", i, 192'(sc_w[i]), 192'(mstall[i]));
            chk("kill_cnt", i, 192'(kc_w[i]), 192'(mkill[i]));
        end
    endtask

    task automatic update_model();
        bit r;
        bit of;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mcnt[i] = 0;
                mstall[i] = 0;
                mkill[i] = 0;
            end else begin
                r  = exp_rdy(i);
                of = (mcnt[i] > 0) && out_ready;
                if (mcnt[i] > 0 && !out_ready) mstall[i] = sat(mstall[i] + 1, i);
                if (flush) begin
                    mkill[i] = sat(mkill[i] + mcnt[i] - (of ? 1 : 0), i);
                    mcnt[i] = 0;
                end else begin
                    if (of) begin
                        mslot[i][0] = mslot[i][1];
                        mcnt[i]--;
                    end
                    if (in_valid && r) begin
                        mslot[i][mcnt[i]] = {in_ctrl, in_data};
                        mcnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv, input logic orr, input logic [175:0] v);
        @(negedge clk);
        rst = r;
        flush = f;
        in_valid = iv;
        out_ready = orr;
        {in_ctrl, in_data} = v;
        #1;
        if (chk_en) compare_all();
        @(posedge clk);
        update_model();
        if (!r) chk_en = 1'b1;
    endtask

    initial begin
        logic [191:0] rnd;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            mstall[i] = 0;
            mkill[i] = 0;
        end

        // reset with junk on the inputs
        step(1'b0, 1'b0, 1'b1, 1'b0, {16'hFFFF, 160'd0});
        step(1'b0, 1'b1, 1'b1, 1'b1, {16'hFFFF, 160'd0});
        #2;
        chk("rst_valid", 0, 192'(ov_w[0]), 192'd0);
        chk("rst_ctrl", 0, 192'(oc_w[0]), 192'd0);
        chk("rst_stall", 0, 192'(sc_w[0]), 192'd0);
        chk("rst_kill", 2, 192'(kc_w[2]), 192'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 176'd0);
        #2;
        chk("rst_ready", 0, 192'(rdy_w[0]), 192'd1);

        // streaming 1..8
        for (int x = 1; x <= 8; x++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, mk(x));
            #2;
            chk("stream_data", 0, 192'(od_w[0]), 192'(x));
            chk("stream_data_s0", 1, 192'(od_w[1]), 192'(x));
            chk("stream_rdy_s0", 1, 192'(rdy_w[1]), 192'd1);
            chk("model_stream", 0, 192'(mslot[0][0][159:0]), 192'(x));
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 176'd0);
        #2;
        chk("stream_stall", 0, 192'(sc_w[0]), 192'd0);

        // backpressure A,B
        step(1'b0, 1'b0, 1'b0, 1'b0, 176'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(10));
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(11));
        step(1'b1, 1'b0, 1'b0, 1'b0, 176'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 176'd0);
        #2;
        chk("bp_ready", 0, 192'(rdy_w[0]), 192'd0);
        chk("bp_stall", 0, 192'(sc_w[0]), 192'd3);
        chk("model_bp_stall", 0, 192'(mstall[0]), 192'd3);
        chk("bp_head_a", 0, 192'(od_w[0]), 192'd10);
        chk("bp_ready_s0", 1, 192'(rdy_w[1]), 192'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 176'd0);
        #2;
        chk("bp_head_b", 0, 192'(od_w[0]), 192'd11);
        step(1'b1, 1'b0, 1'b0, 1'b1, 176'd0);
        #2;
        chk("bp_drained", 0, 192'(ov_w[0]), 192'd0);

        // flush with two held entries and a concurrent push
        step(1'b0, 1'b0, 1'b0, 1'b0, 176'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(20));
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(21));
        step(1'b1, 1'b1, 1'b1, 1'b0, mk(22));
        #2;
        chk("fl_valid", 0, 192'(ov_w[0]), 192'd0);
        chk("fl_ctrl", 0, 192'(oc_w[0]), 192'd0);
        chk("fl_kill", 0, 192'(kc_w[0]), 192'd2);
        chk("model_fl_kill", 0, 192'(mkill[0]), 192'd2);
        chk("fl_kill_s0", 1, 192'(kc_w[1]), 192'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 176'd0);
        #2;
        chk("fl_no_c", 0, 192'(ov_w[0]), 192'd0);

        // flush while the only entry is delivered
        step(1'b0, 1'b0, 1'b0, 1'b0, 176'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(30));
        #2;
        chk("flo_head", 0, 192'(od_w[0]), 192'd30);
        step(1'b1, 1'b1, 1'b0, 1'b1, 176'd0);
        #2;
        chk("flo_kill", 0, 192'(kc_w[0]), 192'd0);
        chk("flo_empty", 0, 192'(ov_w[0]), 192'd0);

        // stall counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b0, 176'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(40));
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, 176'd0);
        #2;
        chk("sat_stall4", 2, 192'(sc_w[2]), 192'd15);
        chk("sat_stall16", 0, 192'(sc_w[0]), 192'd20);
        chk("model_sat", 2, 192'(mstall[2]), 192'd15);

        // kill counter: the add of 2 at 14 must clamp
        step(1'b0, 1'b0, 1'b0, 1'b0, 176'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, mk(50 + k));
            step(1'b1, 1'b0, 1'b1, 1'b0, mk(60 + k));
            step(1'b1, 1'b1, 1'b0, 1'b0, 176'd0);
        end
        #2;
        chk("sat_kill4", 2, 192'(kc_w[2]), 192'd15);
        chk("sat_kill16", 0, 192'(kc_w[0]), 192'd16);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 rnd[175:0]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 176'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
